ula_seq: RTL and testbench
==========================

# ula_seq

Sequential, parametrised successor to the team's combinational 4-bit-opcode ALU.
- Keeps the same 16-entry opcode map and generalises operands to WIDTH bits.
- Registers the result, and adds a start/busy/done handshake and status flags.
- Replaces the combinational multiply and divide with iterative multi-cycle units (shift-add, restoring division).
- Sits between the control unit (which issues Sel/A/B/inicio) and the register file (which captures Saida on pronto).

## Interface

Parameters:
- WIDTH, 8, operand width in bits; integer ≥ 2.
- SHW, $clog2(WIDTH), width of the shift/rotate amount taken from B[SHW-1:0].

Ports:
- clk  in  1  clock. Single clock domain; all state changes on the rising edge.
- rst_n  in  1  reset. Asynchronous assertion, active-low.
- inicio  in  1  start request.
- Sel  in  4  opcode.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- Saida  out  2*WIDTH  registered result.
- pronto  out  1  one-cycle result-valid pulse.
- ocupado  out  1  high while a multi-cycle operation runs.
- zero  out  1  registered: Saida == 0.
- erro  out  1  registered: the last operation was a divide by zero.

## Operation

- Acceptance: a request is accepted on a rising edge where inicio=1 and ocupado=0. Sel, A and B are latched at that edge. inicio while ocupado=1 is ignored; it is neither queued nor an error.
- Unless stated otherwise, results are zero-extended into Saida.
- Opcode map:
  - 0000 add: Saida[WIDTH:0] = A+B (carry in bit WIDTH).
  - 0001 sub: Saida[WIDTH:0] = {borrow, A-B mod 2^WIDTH}; borrow=1 iff A<B.
  - 0010 mul: Saida = A*B, full 2*WIDTH bits, iterative.
  - 0011 div: Saida = {resto, quociente}, each WIDTH bits, iterative restoring.
  - 0100 / 0101: logical shift left / right of A by B[SHW-1:0]; result WIDTH bits.
  - 0110 / 0111: rotate right / left of A by B[SHW-1:0].
  - 1000-1101: bitwise AND, OR, XOR, NAND, NOR, XNOR of A and B; WIDTH bits.
  - 1110: Saida = 1 if A<B (unsigned), else 0.
  - 1111: Saida = 1 if A==B, else 0.
- Divide by zero (0011 with B=0) takes the fast path: quociente = all ones, resto = A, erro=1.
- erro clears on the next accepted operation.
- zero is computed from the value written to Saida in the same cycle.
- FSM states:
  - OCIOSO: waiting. Accepting 0010 (or 0011 with B≠0) → CALC. Any other accepted opcode stays in OCIOSO and completes immediately.
  - CALC: iteration counter counts 0..WIDTH-1. On the edge where counter = WIDTH-1, write Saida/flags, pulse pronto, return to OCIOSO.
- Saida, zero and erro hold their value until the next completion.

## Timing

- Reset values: Saida=0, pronto=0, ocupado=0, zero=1, erro=0; FSM=OCIOSO; counter=0. Reset mid-CALC aborts the operation immediately, with no pronto.
- Fast ops: accepted at edge k → Saida/flags valid and pronto=1 after edge k. Latency 1 cycle; ocupado stays 0.
- Back-to-back fast ops: one per cycle; pronto stays high continuously.
- Multi-cycle (mul, div with B≠0):
  - Accepted at edge k → ocupado=1 after edge k.
  - Iterations occur on edges k+1 through k+WIDTH.
  - After edge k+WIDTH: Saida valid, pronto=1 for exactly one cycle, ocupado=0. Latency is WIDTH+1 edges.
  - The earliest next acceptance is edge k+WIDTH+1.
- pronto is never high in a cycle where ocupado=1.
- Changes to A/B/Sel during CALC have no effect on the result.

## Test plan

- Reset/idle: assert rst_n=0 mid-run → Saida=0, zero=1, pronto=0, ocupado=0 immediately, before any clock edge.
- Arithmetic, WIDTH=8:
  - add A=0xFF, B=0x01 → Saida=0x0100, pronto 1 cycle after acceptance.
  - sub A=0x03, B=0x05 → Saida=0x01FE.
  - 1110 on A=3, B=5 → Saida=1.
- Multiply, WIDTH=8: A=0xFF, B=0xFF → ocupado high for 8 cycles, then Saida=0xFE01 and pronto for one cycle. A second inicio sent during CALC is ignored.
- Divide, WIDTH=8:
  - A=100, B=7 → Saida={0x02, 0x0E}, latency 9 edges.
  - A=0x55, B=0 → 1-cycle completion, Saida={0x55, 0xFF}, erro=1.
  - Next add clears erro.
- Shift/rotate, WIDTH=8, A=0x81:
  - rotate left by 1 → 0x03.
  - rotate right by 1 → 0xC0.
  - shift left by 3 → 0x08.
  - B=0x09 uses amount 1 → shift right gives 0x40.
- Reset mid-operation: start mul, drop rst_n at iteration 4 → no pronto, FSM=OCIOSO. A new add after reset completes correctly.

Source files
------------

// File: rtl/ula_seq.sv
// Sequential WIDTH-bit ALU with a 16-entry opcode map, start/done handshake and
// iterative shift-add multiply and restoring divide.
module ula_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inicio,
  input  logic [3:0]         Sel,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Saida,
  output logic               pronto,
  output logic               ocupado,
  output logic               zero,
  output logic               erro
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic {OCIOSO, CALC} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [2*WIDTH-1:0] saida_q, saida_d;
  logic               pronto_q, pronto_d;
  logic               zero_q, zero_d;
  logic               erro_q, erro_d;

  // Single-cycle operations, evaluated straight from the inputs at acceptance.
  logic [WIDTH:0]     add_sum, sub_diff;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] dup, rot_r, rot_l;
  logic [2*WIDTH-1:0] fast_res;

  assign add_sum  = {1'b0, A} + {1'b0, B};
  assign sub_diff = {1'b0, A} - {1'b0, B};
  assign shamt    = B[SHW-1:0];
  assign dup      = {A, A};
  assign rot_r    = dup >> shamt;
  assign rot_l    = dup << shamt;

  always_comb begin
    fast_res = '0;
    case (Sel)
      4'b0000: fast_res = {{(WIDTH-1){1'b0}}, add_sum};
      4'b0001: fast_res = {{(WIDTH-1){1'b0}}, sub_diff};
      4'b0011: fast_res = {A, {WIDTH{1'b1}}};
      4'b0100: fast_res = {{WIDTH{1'b0}}, A << shamt};
      4'b0101: fast_res = {{WIDTH{1'b0}}, A >> shamt};
      4'b0110: fast_res = {{WIDTH{1'b0}}, rot_r[WIDTH-1:0]};
      4'b0111: fast_res = {{WIDTH{1'b0}}, rot_l[2*WIDTH-1:WIDTH]};
      4'b1000: fast_res = {{WIDTH{1'b0}}, A & B};
      4'b1001: fast_res = {{WIDTH{1'b0}}, A | B};
      4'b1010: fast_res = {{WIDTH{1'b0}}, A ^ B};
      4'b1011: fast_res = {{WIDTH{1'b0}}, ~(A & B)};
      4'b1100: fast_res = {{WIDTH{1'b0}}, ~(A | B)};
      4'b1101: fast_res = {{WIDTH{1'b0}}, ~(A ^ B)};
      4'b1110: fast_res = {{(2*WIDTH-1){1'b0}}, A < B};
      4'b1111: fast_res = {{(2*WIDTH-1){1'b0}}, A == B};
      default: fast_res = '0;
    endcase
  end

  // Multiply: work = {partial, multiplier}; add multiplicand on LSB, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

  // Divide: work = {remainder, dividend/quotient}; quotient bits enter at the LSB.
  logic [WIDTH:0]     div_r, div_t;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next, step;
  assign div_r    = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_t    = div_r - {1'b0, opnd_q};
  assign div_ge   = ~div_t[WIDTH];
  assign div_next = {(div_ge ? div_t[WIDTH-1:0] : div_r[WIDTH-1:0]),
                     work_q[WIDTH-2:0], div_ge};
  assign step     = is_div_q ? div_next : mul_next;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    work_d   = work_q;
    saida_d  = saida_q;
    pronto_d = 1'b0;
    zero_d   = zero_q;
    erro_d   = erro_q;
    case (state_q)
      OCIOSO: begin
        if (inicio) begin
          erro_d = 1'b0;
          if (Sel == OP_MUL || (Sel == OP_DIV && B != '0)) begin
            state_d  = CALC;
            cnt_d    = '0;
            is_div_d = (Sel == OP_DIV);
            opnd_d   = (Sel == OP_DIV) ? B : A;
            work_d   = (Sel == OP_DIV) ? {{WIDTH{1'b0}}, A} : {{WIDTH{1'b0}}, B};
          end else begin
            saida_d  = fast_res;
            zero_d   = (fast_res == '0);
            erro_d   = (Sel == OP_DIV);
            pronto_d = 1'b1;
          end
        end
      end
      CALC: begin
        work_d = step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          saida_d  = step;
          zero_d   = (step == '0);
          pronto_d = 1'b1;
          cnt_d    = '0;
          state_d  = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OCIOSO;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      work_q   <= '0;
      saida_q  <= '0;
      pronto_q <= 1'b0;
      zero_q   <= 1'b1;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      work_q   <= work_d;
      saida_q  <= saida_d;
      pronto_q <= pronto_d;
      zero_q   <= zero_d;
      erro_q   <= erro_d;
    end
  end

  assign Saida   = saida_q;
  assign pronto  = pronto_q;
  assign ocupado = (state_q == CALC);
  assign zero    = zero_q;
  assign erro    = erro_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq at WIDTH=8: fast ops, iterative mul/div, flags, reset.
module tb_ula_seq;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           inicio = 1'b0;
  logic [3:0]     Sel = '0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [2*W-1:0] Saida;
  logic           pronto, ocupado, zero, erro;

  int n_cmp = 0;
  int n_err = 0;

  ula_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .Sel(Sel), .A(A), .B(B),
    .Saida(Saida), .pronto(pronto), .ocupado(ocupado), .zero(zero), .erro(erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request presented before an edge, inicio dropped just after it; returns 1 ns past the edge.
  task automatic issue(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    inicio = 1'b1; Sel = s; A = a; B = b;
    @(posedge clk); #1;
    inicio = 1'b0;
  endtask

  task automatic fast(input string tag, input logic [3:0] s, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [15:0] exp);
    issue(s, a, b);
    chk({tag, "_saida"}, 32'(Saida), 32'(exp));
    chk({tag, "_pronto"}, 32'(pronto), 32'd1);
    chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_saida", 32'(Saida), 32'h0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    fast("add_ff_01", 4'b0000, 8'hFF, 8'h01, 16'h0100);
    chk("add_zero", 32'(zero), 32'd0);
    @(posedge clk); #1;
    chk("add_pronto_drop", 32'(pronto), 32'd0);

    fast("sub_3_5", 4'b0001, 8'h03, 8'h05, 16'h01FE);
    fast("lt_3_5", 4'b1110, 8'h03, 8'h05, 16'h0001);
    fast("eq_5a", 4'b1111, 8'h5A, 8'h5A, 16'h0001);
    fast("and_zero", 4'b1000, 8'h0F, 8'hF0, 16'h0000);
    chk("and_zero_flag", 32'(zero), 32'd1);
    fast("xnor", 4'b1101, 8'hF0, 8'hCC, 16'h00C3);

    // Multiply 0xFF*0xFF with an extra inicio mid-computation that must be ignored.
    issue(4'b0010, 8'hFF, 8'hFF);
    chk("mul_ocupado_k", 32'(ocupado), 32'd1);
    chk("mul_pronto_k", 32'(pronto), 32'd0);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (i == 3) begin inicio = 1'b1; Sel = 4'b0000; A = 8'h01; B = 8'h01; end
      else inicio = 1'b0;
      @(posedge clk); #1;
      if (i < W) begin
        chk($sformatf("mul_ocupado_%0d", i), 32'(ocupado), 32'd1);
        chk($sformatf("mul_pronto_%0d", i), 32'(pronto), 32'd0);
      end
    end
    chk("mul_saida", 32'(Saida), 32'hFE01);
    chk("mul_pronto", 32'(pronto), 32'd1);
    chk("mul_ocupado_end", 32'(ocupado), 32'd0);
    @(posedge clk); #1;
    chk("mul_pronto_once", 32'(pronto), 32'd0);
    chk("mul_hold", 32'(Saida), 32'hFE01);

    // Divide 100/7 -> quotient 14, remainder 2; latency WIDTH+1 edges.
    issue(4'b0011, 8'd100, 8'd7);
    chk("div_ocupado_k", 32'(ocupado), 32'd1);
    A = 8'h00; B = 8'h00; Sel = 4'b1111;
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      chk($sformatf("div_pronto_%0d", i), 32'(pronto), 32'd0);
    end
    @(posedge clk); #1;
    chk("div_saida", 32'(Saida), 32'h020E);
    chk("div_pronto", 32'(pronto), 32'd1);
    chk("div_erro", 32'(erro), 32'd0);

    fast("div0", 4'b0011, 8'h55, 8'h00, 16'h55FF);
    chk("div0_erro", 32'(erro), 32'd1);
    fast("add_clr", 4'b0000, 8'h01, 8'h02, 16'h0003);
    chk("add_clr_erro", 32'(erro), 32'd0);

    fast("rotl_1", 4'b0111, 8'h81, 8'h01, 16'h0003);
    fast("rotr_1", 4'b0110, 8'h81, 8'h01, 16'h00C0);
    fast("shl_3", 4'b0100, 8'h81, 8'h03, 16'h0008);
    fast("shr_9", 4'b0101, 8'h81, 8'h09, 16'h0040);

    // Reset in the middle of a multiply: aborts at once, no pronto.
    issue(4'b0010, 8'h12, 8'h34);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_ocupado", 32'(ocupado), 32'd0);
    chk("rstmid_saida", 32'(Saida), 32'h0);
    chk("rstmid_zero", 32'(zero), 32'd1);
    chk("rstmid_pronto", 32'(pronto), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid_pronto_held", 32'(pronto), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    fast("add_after_rst", 4'b0000, 8'h10, 8'h20, 16'h0030);
    repeat (W + 1) @(posedge clk);
    #1;
    chk("no_late_pronto", 32'(pronto), 32'd0);
    chk("idle_ocupado", 32'(ocupado), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
